// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: operand/op input channel, result output
// channel and the busy indication used by the hazard unit.
interface alu_pipe_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic             busy;

  // Producer/consumer side (pipeline control and EX/MEM consumer)
  modport master (
    output in_valid, a, b, alu_op, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal, busy
  );

  // ALU side
  modport slave (
    input  in_valid, a, b, alu_op, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU with valid/ready handshake on both sides, signed
// overflow and illegal-op flags, and an iterative shift-add multiplier that
// holds off new operands while it runs.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  alu_if
);

  localparam int SW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_NOR  = 4'b0100,
    OP_SLTU = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_MUL  = 4'b1100
  } op_t;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    count_q, count_d;

  logic             in_ready;
  logic             accept;
  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;
  logic             is_mul;
  logic [WIDTH-1:0] acc_next;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || alu_if.out_ready);
  assign accept   = alu_if.in_valid && in_ready;

  assign alu_if.in_ready  = in_ready;
  assign alu_if.out_valid = out_valid_q;
  assign alu_if.result    = result_q;
  assign alu_if.zero      = zero_q;
  assign alu_if.overflow  = ovf_q;
  assign alu_if.illegal   = ill_q;
  assign alu_if.busy      = (state_q == S_MUL);

  // Single-cycle ALU: result, overflow and illegal decode for the presented op
  always_comb begin
    sh      = alu_if.b[SW-1:0];
    sum     = alu_if.a + alu_if.b;
    diff    = alu_if.a - alu_if.b;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    is_mul  = 1'b0;
    case (op_t'(alu_if.alu_op))
      OP_AND:  alu_res = alu_if.a & alu_if.b;
      OP_OR:   alu_res = alu_if.a | alu_if.b;
      OP_XOR:  alu_res = alu_if.a ^ alu_if.b;
      OP_NOR:  alu_res = ~(alu_if.a | alu_if.b);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (alu_if.a[MSB] == alu_if.b[MSB]) && (sum[MSB] != alu_if.a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (alu_if.a[MSB] != alu_if.b[MSB]) && (diff[MSB] != alu_if.a[MSB]);
      end
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (alu_if.a < alu_if.b)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(alu_if.a) < $signed(alu_if.b))};
      OP_SLL:  alu_res = alu_if.a << sh;
      OP_SRL:  alu_res = alu_if.a >> sh;
      OP_SRA:  alu_res = WIDTH'($signed(alu_if.a) >>> sh);
      OP_MUL: begin
        if (MUL_EN) is_mul  = 1'b1;
        else        alu_ill = 1'b1;
      end
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state: accept/retire in IDLE, one shift-add iteration per MUL cycle
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    count_d     = count_q;
    acc_next    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    case (state_q)
      S_IDLE: begin
        if (out_valid_q && alu_if.out_ready) out_valid_d = 1'b0;
        if (accept) begin
          if (is_mul) begin
            state_d     = S_MUL;
            mcand_d     = alu_if.a;
            mplier_d    = alu_if.b;
            acc_d       = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
          end else begin
            // a new accept on a consuming edge replaces the old result directly
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
            ill_d       = alu_ill;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == SW'(WIDTH - 1)) begin
          state_d     = S_IDLE;
          result_d    = acc_next;
          zero_d      = (acc_next == '0);
          ovf_d       = 1'b0;
          ill_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, hand-written multi-cycle
// sequences (multiply latency, backpressure, reset abort, MUL_EN=0) and a
// randomized run scored against a plain-arithmetic reference model.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(32)) bus ();
  alu_pipe_if #(.WIDTH(32)) bus0 ();

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .alu_if (bus)
  );

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b0)) u_dut_nomul (
    .clk    (clk),
    .rst    (rst),
    .alu_if (bus0)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        ov;
    logic        ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: defined directly from the op semantics using wide arithmetic
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit mul_en);
    exp_t   e;
    longint sa, sb2, s;
    int unsigned amt;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    amt = int'(b % 32);
    e.r = 32'd0; e.ov = 1'b0; e.ill = 1'b0;
    case (op)
      4'd0:  e.r = a & b;
      4'd1:  e.r = a | b;
      4'd2:  begin s = sa + sb2; e.r = 32'(s);
                   e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd3:  e.r = a ^ b;
      4'd4:  e.r = ~(a | b);
      4'd5:  e.r = (a < b) ? 32'd1 : 32'd0;
      4'd6:  begin s = sa - sb2; e.r = 32'(s);
                   e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7:  e.r = (sa < sb2) ? 32'd1 : 32'd0;
      4'd8:  e.r = 32'(64'(a) << amt);
      4'd9:  e.r = 32'(64'(a) >> amt);
      4'd10: e.r = 32'(sa >>> amt);
      4'd12: if (mul_en) e.r = 32'(64'(a) * 64'(b)); else e.ill = 1'b1;
      default: e.ill = 1'b1;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int   edges, busy_cycles, stale;
    logic acc, hold;
    exp_t e;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.alu_op = '0; bus.out_ready = 1'b1;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.alu_op = '0; bus0.out_ready = 1'b1;

    vecs.push_back('{4'h0, 32'd10, 32'd7, 32'd2,          1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h1, 32'd10, 32'd7, 32'd15,         1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h2, 32'd10, 32'd7, 32'd17,         1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h6, 32'd10, 32'd7, 32'd3,          1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h3, 32'd10, 32'd7, 32'd13,         1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h4, 32'd10, 32'd7, 32'hFFFF_FFF0,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h7, 32'd10, 32'd7, 32'd0,          1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'h5, 32'd10, 32'd7, 32'd0,          1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'h2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'h6, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'h6, 32'd5, 32'd5, 32'd0,           1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'hA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h9, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h8, 32'd1, 32'd31, 32'h8000_0000,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h7, 32'hFFFF_FFFF, 32'd1, 32'd1,   1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h5, 32'hFFFF_FFFF, 32'd1, 32'd0,   1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'hF, 32'd10, 32'd7, 32'd0,          1'b1, 1'b0, 1'b1});
    vecs.push_back('{4'hB, 32'h8000_0000, 32'd3, 32'd0,   1'b1, 1'b0, 1'b1});
    vecs.push_back('{4'h2, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 1'b1, 1'b0});

    // ---- reset ----
    #1 rst = 1'b1;
    tick(); tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result",    64'(bus.result),    64'd0);
    chk("rst_zero",      64'(bus.zero),      64'd0);
    chk("rst_overflow",  64'(bus.overflow),  64'd0);
    chk("rst_illegal",   64'(bus.illegal),   64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);

    // ---- directed table, back-to-back with out_ready=1 ----
    foreach (vecs[i]) begin
      bus.in_valid = 1'b1; bus.alu_op = vecs[i].op; bus.a = vecs[i].a; bus.b = vecs[i].b;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
      tick();
      chk($sformatf("tbl%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("tbl%0d_result", i),    64'(bus.result),    64'(vecs[i].res));
      chk($sformatf("tbl%0d_zero", i),      64'(bus.zero),      64'(vecs[i].z));
      chk($sformatf("tbl%0d_overflow", i),  64'(bus.overflow),  64'(vecs[i].ov));
      chk($sformatf("tbl%0d_illegal", i),   64'(bus.illegal),   64'(vecs[i].ill));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("tbl_drain_out_valid", 64'(bus.out_valid), 64'd0);

    // ---- multiply latency: 10*7 ----
    bus.in_valid = 1'b1; bus.alu_op = 4'hC; bus.a = 32'd10; bus.b = 32'd7;
    tick();
    bus.in_valid = 1'b0;
    edges = 1; busy_cycles = 0;
    while (!bus.out_valid && edges < 100) begin
      if (bus.busy && !bus.in_ready) busy_cycles++;
      tick();
      edges++;
    end
    chk("mul_edges",     64'(edges),       64'd33);
    chk("mul_busy_cyc",  64'(busy_cycles), 64'd32);
    chk("mul_result",    64'(bus.result),  64'd70);
    chk("mul_zero",      64'(bus.zero),    64'd0);
    chk("mul_illegal",   64'(bus.illegal), 64'd0);
    chk("mul_busy_done", 64'(bus.busy),    64'd0);

    // ---- multiply wrap: 0xFFFFFFFF^2 ----
    bus.in_valid = 1'b1; bus.alu_op = 4'hC; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
    tick();
    bus.in_valid = 1'b0;
    edges = 1;
    while (!bus.out_valid && edges < 100) begin tick(); edges++; end
    chk("mulff_edges",  64'(edges),      64'd33);
    chk("mulff_result", 64'(bus.result), 64'd1);

    // ---- backpressure ----
    bus.in_valid = 1'b1; bus.alu_op = 4'h2; bus.a = 32'd10; bus.b = 32'd7;
    tick();
    bus.out_ready = 1'b0;
    bus.alu_op = 4'h0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c),  64'(bus.in_ready),  64'd0);
      tick();
      chk($sformatf("bp%0d_out_valid", c), 64'(bus.out_valid), 64'd1);
      chk($sformatf("bp%0d_result", c),    64'(bus.result),    64'd17);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_second_valid",  64'(bus.out_valid), 64'd1);
    chk("bp_second_result", 64'(bus.result),    64'd2);
    tick();
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // ---- reset mid-multiply ----
    bus.in_valid = 1'b1; bus.alu_op = 4'hC; bus.a = 32'd3; bus.b = 32'd5;
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    chk("rmul_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("rmul_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rmul_result",    64'(bus.result),    64'd0);
    chk("rmul_zero",      64'(bus.zero),      64'd0);
    chk("rmul_busy",      64'(bus.busy),      64'd0);
    rst = 1'b0;
    tick();
    chk("rmul_in_ready",  64'(bus.in_ready),  64'd1);
    stale = 0;
    repeat (40) begin
      if (bus.out_valid) stale++;
      tick();
    end
    chk("rmul_no_stale", 64'(stale), 64'd0);

    // ---- MUL_EN=0 makes MUL illegal ----
    bus0.in_valid = 1'b1; bus0.alu_op = 4'hC; bus0.a = 32'd10; bus0.b = 32'd7;
    tick();
    bus0.in_valid = 1'b0;
    chk("nomul_out_valid", 64'(bus0.out_valid), 64'd1);
    chk("nomul_illegal",   64'(bus0.illegal),   64'd1);
    chk("nomul_result",    64'(bus0.result),    64'd0);
    chk("nomul_zero",      64'(bus0.zero),      64'd1);
    chk("nomul_busy",      64'(bus0.busy),      64'd0);

    // ---- randomized traffic against the reference model ----
    hold = 1'b0;
    for (int it = 0; it < 400; it++) begin
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 9) < 7);
        bus.alu_op   = ($urandom_range(0, 15) == 0) ? 4'hC : 4'($urandom_range(0, 15));
        bus.a        = rnd_operand();
        bus.b        = rnd_operand();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("rnd_spurious_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          chk("rnd_result",   64'(bus.result),   64'(sb[0].r));
          chk("rnd_zero",     64'(bus.zero),     64'(sb[0].z));
          chk("rnd_overflow", 64'(bus.overflow), 64'(sb[0].ov));
          chk("rnd_illegal",  64'(bus.illegal),  64'(sb[0].ill));
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
      if (acc) begin
        e = model(bus.alu_op, bus.a, bus.b, 1'b1);
        sb.push_back(e);
      end
      hold = bus.in_valid && !acc;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    edges = 0;
    while (sb.size() != 0 && edges < 100) begin
      if (bus.out_valid) begin
        chk("rnd_drain_result", 64'(bus.result), 64'(sb[0].r));
        void'(sb.pop_front());
      end
      tick();
      edges++;
    end
    chk("rnd_drain_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational EX-stage ALU of the five-stage pipeline.
- Adds a valid/ready handshake on input and output, a wider 4-bit op set (shifts, XOR/NOR, unsigned compare), signed-overflow and illegal-op flags, and an iterative shift-add multiplier.
- Sits in EX. Hazard/stall logic uses in_ready and busy to hold ID/EX while a multiply runs.

Parameters:
- WIDTH, 32: operand/result width in bits, >=4. Shift amount is b[$clog2(WIDTH)-1:0].
- MUL_EN, 1: 1 implements the iterative MUL op; 0 makes MUL an illegal op.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and op presented
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- alu_op  in  4  operation select
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- zero  out  1  registered (result == 0)
- overflow  out  1  registered signed overflow; ADD/SUB only, else 0
- illegal  out  1  registered: op was unimplemented
- busy  out  1  multiply in progress

Behaviour:
- Reset (async, immediate on rst=1): state=IDLE; out_valid=0, result=0, zero=0, overflow=0, illegal=0, busy=0. Any multiply in flight is aborted with no output.
- Op encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLTU, 0110 SUB, 0111 SLT.
  - 1000 SLL, 1001 SRL, 1010 SRA, 1100 MUL (low WIDTH bits of unsigned product).
  - All other codes are illegal.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow=1 when operand signs force a wrong-sign result (ADD: a,b same sign, result differs; SUB: a,b differ, result sign != a sign).
  - SLT/SLTU give 1 or 0 zero-extended.
  - SRA replicates a[WIDTH-1].
- Illegal op: completes in 1 cycle with result=0, zero=1, overflow=0, illegal=1.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational; no dependence on in_valid.
- Accept: in_valid && in_ready at a rising edge. Inputs are sampled only at that edge.
- Single-cycle ops: result and flags register at the accepting edge; out_valid=1 after it (latency 1). Back-to-back accepts give one result per cycle while out_ready=1.
- Output hold: while out_valid=1 && out_ready=0, result/zero/overflow/illegal/out_valid are stable and in_ready=0.
- out_valid clears on an edge with out_ready=1 unless a new accept occurs on that same edge; the new result then replaces the old one with no bubble.
- FSM: IDLE -> MUL on accept of MUL (MUL_EN=1). MUL -> IDLE after WIDTH iteration edges.
- Multiply datapath:
  - Accepting edge loads multiplicand=a, multiplier=b, acc=0, count=0, busy=1, out_valid=0.
  - If out_valid was 1 on that edge, out_ready=1 was required, so no result is lost.
  - Each MUL edge: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++.
  - On the WIDTH-th iteration edge: result=acc (incl. final add), zero updated, overflow=0, illegal=0, out_valid=1, busy=0, state=IDLE.
  - Latency WIDTH+1 edges from the accept edge to out_valid visible. in_ready=0 throughout MUL.
- Simultaneous events:
  - rst overrides everything.
  - out_ready during MUL has no effect; out_valid is already 0.
- in_valid with in_ready=0 is ignored. The producer must hold its inputs.

Test Plan:
- Reset, then ops with a=10, b=7, out_ready=1, one per cycle. Each result appears one cycle after accept, with no bubbles:
  - AND 2, OR 15, ADD 17, SUB 3, XOR 13, NOR 0xFFFFFFF0.
  - SLT 0, SLTU 0.
  - zero=1 only for SLT/SLTU.
- Overflow checks:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1.
  - SUB 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
  - SUB 5-5 -> 0, zero=1, overflow=0.
- Shift and compare checks:
  - SRA 0x80000000 by b=4 -> 0xF8000000; SRL -> 0x08000000; SLL 1 by 31 -> 0x80000000.
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU -> 0.
- Multiply:
  - MUL 10*7 -> out_valid exactly 33 edges after accept, result 70; busy=1 and in_ready=0 for 32 cycles.
  - MUL 0xFFFFFFFF*0xFFFFFFFF -> 1.
- Backpressure: hold out_ready=0 for 5 cycles after ADD 10+7. result stays 17, in_ready=0, a second in_valid is not accepted. Release out_ready, then the second op is accepted.
- Reset/illegal:
  - rst pulse mid-multiply (cycle 10) -> all outputs 0 immediately, in_ready=1 next cycle, no stale result.
  - alu_op=1111 -> result 0, zero=1, illegal=1.
  - With MUL_EN=0, MUL -> illegal=1.
